// File: rtl/pattern_scheduler.sv
// ---------------------------------------------------------------------------
// pattern_scheduler
//   Frame-synchronous sequencer for the HDMI test-pattern generator. Picks the
//   pattern index used by the pixel-data stage and only changes it on a frame
//   tick, so a frame never tears mid-picture. The pattern advances either
//   automatically every DWELL_FRAMES frames, or on a manual request.
//
// Ports
//   pixel_clk    in   pixel clock, all logic on its rising edge
//   sys_rst      in   synchronous active-high reset
//   vsync        in   active-high vertical sync (already in pixel_clk domain)
//   auto_en      in   level, 1 = auto-advance enabled
//   pause        in   level, 1 = freeze auto dwell counting
//   next_req     in   manual advance request
//   next_ack     out  1-cycle pulse, request accepted
//   pattern_sel  out  current pattern index (0..NUM_PAT-1)
//   pattern_chg  out  1-cycle pulse coincident with a pattern_sel update
//   req_pend     out  manual request accepted but not yet applied
//   frame_cnt    out  frames since reset, wraps at 2**FCNT_W
//   state_dbg    out  FSM state (0 IDLE, 1 RUN, 2 PAUSE)
//
// Request handshake: a request is the rising edge of next_req, detected
// against its value one cycle earlier. The scheduler is always ready, so each
// edge is answered by a one-cycle next_ack on the following clock edge and
// sets req_pend. next_req may stay high afterwards; another request needs
// next_req low for at least one cycle. Edges that arrive while req_pend is
// already set are acked but merge into the one pending advance.
// ---------------------------------------------------------------------------
module pattern_scheduler #(
    parameter int NUM_PAT      = 4,
    parameter int PAT_W        = 2,
    parameter int DWELL_FRAMES = 120,
    parameter int FCNT_W       = 16
) (
    input  logic              pixel_clk,
    input  logic              sys_rst,
    input  logic              vsync,
    input  logic              auto_en,
    input  logic              pause,
    input  logic              next_req,
    output logic              next_ack,
    output logic [PAT_W-1:0]  pattern_sel,
    output logic              pattern_chg,
    output logic              req_pend,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [1:0]        state_dbg
);

    localparam int                 DWELL_W    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(NUM_PAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               vs_d1;
    logic               vs_d2;
    logic               req_d;
    logic               tick;
    logic               req_edge;
    logic [DWELL_W-1:0] dwell;
    logic               in_run;
    logic               dwell_clr;
    logic               adv_manual;
    logic               adv_auto;
    logic               advance;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // The mode is a pure function of the two level inputs, so every state
    // can reach every other one directly.
    always_comb begin
        state_nxt = state;
        if (!auto_en) begin
            state_nxt = S_IDLE;
        end else if (pause) begin
            state_nxt = S_PAUSE;
        end else begin
            state_nxt = S_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    // dwell_clr also fires on the cycle auto_en drops, so the counter is
    // already zero when the FSM lands in IDLE.
    always_comb begin
        in_run    = (state == S_RUN);
        dwell_clr = (state == S_IDLE) || !auto_en;
        state_dbg = state;
    end

    // ---------------- tick / request edge detection ----------------
    // vs_d1/vs_d2 and req_d reset high so a level held across reset release
    // is not mistaken for a fresh edge.
    assign tick     = vs_d1 & ~vs_d2;
    assign req_edge = next_req & ~req_d;

    // A pending request wins over the auto dwell; both only act on a tick.
    assign adv_manual = tick & req_pend;
    assign adv_auto   = tick & in_run & (dwell == DWELL_LAST);
    assign advance    = adv_manual | adv_auto;

    // ---------------- datapath ----------------
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            vs_d1       <= 1'b1;
            vs_d2       <= 1'b1;
            req_d       <= 1'b1;
            next_ack    <= 1'b0;
            req_pend    <= 1'b0;
            pattern_sel <= '0;
            pattern_chg <= 1'b0;
            frame_cnt   <= '0;
            dwell       <= '0;
        end else begin
            vs_d1       <= vsync;
            vs_d2       <= vs_d1;
            req_d       <= next_req;
            next_ack    <= req_edge;
            pattern_chg <= advance;

            if (tick) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end

            // A new edge always leaves a request pending, even when the same
            // tick consumes the previous one: it is applied at the next tick.
            if (req_edge) begin
                req_pend <= 1'b1;
            end else if (adv_manual) begin
                req_pend <= 1'b0;
            end

            if (advance) begin
                pattern_sel <= (pattern_sel == PAT_LAST) ? '0 : pattern_sel + PAT_W'(1);
            end

            if (advance || dwell_clr) begin
                dwell <= '0;
            end else if (tick && in_run) begin
                dwell <= dwell + DWELL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pattern_scheduler
//   Directed bench for pattern_scheduler with NUM_PAT=4, DWELL_FRAMES=3,
//   FCNT_W=4. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pattern_scheduler;

    localparam int NUM_PAT = 4;
    localparam int PAT_W   = 2;
    localparam int DWELL   = 3;
    localparam int FCNT_W  = 4;

    logic              pixel_clk;
    logic              sys_rst;
    logic              vsync;
    logic              auto_en;
    logic              pause;
    logic              next_req;
    logic              next_ack;
    logic [PAT_W-1:0]  pattern_sel;
    logic              pattern_chg;
    logic              req_pend;
    logic [FCNT_W-1:0] frame_cnt;
    logic [1:0]        state_dbg;

    int errors = 0;
    int checks = 0;

    pattern_scheduler #(
        .NUM_PAT      (NUM_PAT),
        .PAT_W        (PAT_W),
        .DWELL_FRAMES (DWELL),
        .FCNT_W       (FCNT_W)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst     (sys_rst),
        .vsync       (vsync),
        .auto_en     (auto_en),
        .pause       (pause),
        .next_req    (next_req),
        .next_ack    (next_ack),
        .pattern_sel (pattern_sel),
        .pattern_chg (pattern_chg),
        .req_pend    (req_pend),
        .frame_cnt   (frame_cnt),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge pixel_clk);
        sys_rst = 1'b0;
        @(negedge pixel_clk);
    endtask

    // ---------------- drivers ----------------
    // One vsync pulse; returns pattern_chg/pattern_sel in the cycle where the
    // tick's updates are visible, then leaves two idle cycles.
    task automatic do_tick(output logic chg, output logic [PAT_W-1:0] sel);
        vsync = 1'b1;
        @(negedge pixel_clk);
        vsync = 1'b0;
        @(negedge pixel_clk);
        chg = pattern_chg;
        sel = pattern_sel;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
    endtask

    // next_req held high for three cycles; counts next_ack pulses.
    task automatic send_req(output int ack_cnt, output logic pend);
        ack_cnt  = 0;
        next_req = 1'b1;
        repeat (3) begin
            @(negedge pixel_clk);
            ack_cnt += int'(next_ack);
        end
        pend     = req_pend;
        next_req = 1'b0;
        @(negedge pixel_clk);
        ack_cnt += int'(next_ack);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vsync = 1'b0; auto_en = 1'b0; pause = 1'b0; next_req = 1'b0;
        apply_reset();
        checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", pattern_sel); end
        checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
        checks++; if (next_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", next_ack); end
        checks++; if (pattern_chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %b want 0", pattern_chg); end
        checks++; if (req_pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b want 0", req_pend); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    endtask

    task automatic test_auto();
        logic [PAT_W-1:0] exp_sel [10];
        logic             exp_chg [10];
        logic             chg;
        logic [PAT_W-1:0] sel;
        exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        exp_chg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        auto_en = 1'b1; pause = 1'b0;
        repeat (2) @(negedge pixel_clk);
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL auto_state got %0d want 1", state_dbg); end
        for (int i = 0; i < 10; i++) begin
            do_tick(chg, sel);
            checks++; if (sel !== exp_sel[i]) begin errors++; $display("FAIL auto_sel[%0d] got %0d want %0d", i, sel, exp_sel[i]); end
            checks++; if (chg !== exp_chg[i]) begin errors++; $display("FAIL auto_chg[%0d] got %b want %b", i, chg, exp_chg[i]); end
        end
        checks++; if (pattern_chg !== 1'b0) begin errors++; $display("FAIL auto_chg_width got %b want 0", pattern_chg); end
        checks++; if (frame_cnt !== 4'd10) begin errors++; $display("FAIL auto_fcnt got %0d want 10", frame_cnt); end
        auto_en = 1'b0;
    endtask

    task automatic test_manual();
        logic [PAT_W-1:0] exp_sel [4];
        logic             chg;
        logic [PAT_W-1:0] sel;
        int               acks;
        int               total_acks;
        logic             pend;
        exp_sel    = '{2'd1, 2'd2, 2'd3, 2'd0};
        total_acks = 0;
        apply_reset();
        auto_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_req(acks, pend);
            total_acks += acks;
            checks++; if (acks !== 1) begin errors++; $display("FAIL man_ack[%0d] got %0d pulses want 1", i, acks); end
            checks++; if (pend !== 1'b1) begin errors++; $display("FAIL man_pend[%0d] got %b want 1", i, pend); end
            // before the tick the index must not have moved
            checks++; if (pattern_sel !== exp_sel[(i + 3) % 4]) begin errors++; $display("FAIL man_hold[%0d] got %0d want %0d", i, pattern_sel, exp_sel[(i + 3) % 4]); end
            do_tick(chg, sel);
            checks++; if (sel !== exp_sel[i]) begin errors++; $display("FAIL man_sel[%0d] got %0d want %0d", i, sel, exp_sel[i]); end
            checks++; if (chg !== 1'b1) begin errors++; $display("FAIL man_chg[%0d] got %b want 1", i, chg); end
            checks++; if (req_pend !== 1'b0) begin errors++; $display("FAIL man_clr[%0d] got %b want 0", i, req_pend); end
            do_tick(chg, sel);
            checks++; if (chg !== 1'b0 || sel !== exp_sel[i]) begin errors++; $display("FAIL man_idle[%0d] got chg=%b sel=%0d want chg=0 sel=%0d", i, chg, sel, exp_sel[i]); end
        end
        checks++; if (total_acks !== 4) begin errors++; $display("FAIL man_total_acks got %0d want 4", total_acks); end
    endtask

    task automatic test_req_on_tick();
        logic             chg;
        logic [PAT_W-1:0] sel;
        apply_reset();
        auto_en = 1'b0;
        vsync = 1'b1;
        @(negedge pixel_clk);
        // the request edge is sampled on the same edge that sees the tick
        vsync    = 1'b0;
        next_req = 1'b1;
        @(negedge pixel_clk);
        checks++; if (next_ack !== 1'b1) begin errors++; $display("FAIL rot_ack got %b want 1", next_ack); end
        checks++; if (req_pend !== 1'b1) begin errors++; $display("FAIL rot_pend got %b want 1", req_pend); end
        checks++; if (pattern_sel !== 2'd0 || pattern_chg !== 1'b0) begin errors++; $display("FAIL rot_noadv got sel=%0d chg=%b want sel=0 chg=0", pattern_sel, pattern_chg); end
        checks++; if (frame_cnt !== 4'd1) begin errors++; $display("FAIL rot_fcnt got %0d want 1", frame_cnt); end
        next_req = 1'b0;
        repeat (3) @(negedge pixel_clk);
        checks++; if (pattern_sel !== 2'd0 || req_pend !== 1'b1) begin errors++; $display("FAIL rot_wait got sel=%0d pend=%b want sel=0 pend=1", pattern_sel, req_pend); end
        do_tick(chg, sel);
        checks++; if (sel !== 2'd1 || chg !== 1'b1) begin errors++; $display("FAIL rot_apply got sel=%0d chg=%b want sel=1 chg=1", sel, chg); end
        checks++; if (req_pend !== 1'b0) begin errors++; $display("FAIL rot_clr got %b want 0", req_pend); end
    endtask

    task automatic test_pause();
        logic             chg;
        logic [PAT_W-1:0] sel;
        int               acks;
        logic             pend;
        apply_reset();
        auto_en = 1'b1; pause = 1'b0;
        repeat (2) @(negedge pixel_clk);
        repeat (2) do_tick(chg, sel);
        pause = 1'b1;
        repeat (2) @(negedge pixel_clk);
        checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL pause_state got %0d want 2", state_dbg); end
        for (int i = 0; i < 5; i++) begin
            do_tick(chg, sel);
            checks++; if (sel !== 2'd0 || chg !== 1'b0) begin errors++; $display("FAIL pause_hold[%0d] got sel=%0d chg=%b want sel=0 chg=0", i, sel, chg); end
        end
        pause = 1'b0;
        repeat (2) @(negedge pixel_clk);
        do_tick(chg, sel);
        checks++; if (sel !== 2'd1 || chg !== 1'b1) begin errors++; $display("FAIL pause_resume got sel=%0d chg=%b want sel=1 chg=1", sel, chg); end
        pause = 1'b1;
        repeat (2) @(negedge pixel_clk);
        send_req(acks, pend);
        checks++; if (acks !== 1 || pend !== 1'b1) begin errors++; $display("FAIL pause_req got acks=%0d pend=%b want acks=1 pend=1", acks, pend); end
        do_tick(chg, sel);
        checks++; if (sel !== 2'd2 || chg !== 1'b1) begin errors++; $display("FAIL pause_manual got sel=%0d chg=%b want sel=2 chg=1", sel, chg); end
        repeat (2) do_tick(chg, sel);
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL pause_after got sel=%0d want 2", sel); end
        pause = 1'b0; auto_en = 1'b0;
    endtask

    task automatic test_vsync_reset_wrap();
        logic             chg;
        logic [PAT_W-1:0] sel;
        auto_en = 1'b0;
        vsync   = 1'b1;
        apply_reset();
        repeat (4) @(negedge pixel_clk);
        checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL vsreset_fcnt got %0d want 0", frame_cnt); end
        vsync = 1'b0;
        repeat (2) @(negedge pixel_clk);
        repeat (18) do_tick(chg, sel);
        checks++; if (frame_cnt !== 4'd2) begin errors++; $display("FAIL wrap_fcnt got %0d want 2", frame_cnt); end
        checks++; if (pattern_sel !== 2'd0) begin errors++; $display("FAIL wrap_sel got %0d want 0", pattern_sel); end
    endtask

    task automatic test_reset_mid_op();
        logic             chg;
        logic [PAT_W-1:0] sel;
        int               acks;
        logic             pend;
        apply_reset();
        auto_en = 1'b1; pause = 1'b0;
        repeat (2) @(negedge pixel_clk);
        repeat (5) do_tick(chg, sel);   // sel=1, dwell=2
        send_req(acks, pend);
        checks++; if (pattern_sel !== 2'd1 || pend !== 1'b1) begin errors++; $display("FAIL mid_setup got sel=%0d pend=%b want sel=1 pend=1", pattern_sel, pend); end
        sys_rst = 1'b1;
        @(negedge pixel_clk);
        checks++; if (pattern_sel !== 2'd0 || req_pend !== 1'b0 || frame_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst got sel=%0d pend=%b fcnt=%0d want 0 0 0", pattern_sel, req_pend, frame_cnt); end
        checks++; if (next_ack !== 1'b0 || pattern_chg !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL mid_rst_pulses got ack=%b chg=%b state=%0d want 0 0 0", next_ack, pattern_chg, state_dbg); end
        sys_rst = 1'b0;
        repeat (2) @(negedge pixel_clk);
        for (int i = 0; i < 2; i++) begin
            do_tick(chg, sel);
            checks++; if (sel !== 2'd0 || chg !== 1'b0) begin errors++; $display("FAIL mid_noadv[%0d] got sel=%0d chg=%b want sel=0 chg=0", i, sel, chg); end
        end
        do_tick(chg, sel);
        checks++; if (sel !== 2'd1 || chg !== 1'b1) begin errors++; $display("FAIL mid_third got sel=%0d chg=%b want sel=1 chg=1", sel, chg); end
        auto_en = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        sys_rst = 1'b1; vsync = 1'b0; auto_en = 1'b0; pause = 1'b0; next_req = 1'b0;
        test_reset();
        test_auto();
        test_manual();
        test_req_on_tick();
        test_pause();
        test_vsync_reset_wrap();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
